// File: rtl/program_memory_pkg.sv
// Shared MiniALU definitions: opcodes, registers, program memory defaults.
// Loader state encodings for program_memory live here too.
package program_memory_pkg;

  localparam int PM_ADDR_WIDTH  = 16;
  localparam int PM_INSTR_WIDTH = 28;
  localparam int PM_DEPTH       = 256;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_LED = 4'hA;

  localparam logic [3:0] REG_A = 4'h0;
  localparam logic [3:0] REG_B = 4'h1;

  localparam logic [PM_INSTR_WIDTH-1:0]
    PM_DEFAULT_INSTR = {OP_LED, 24'h0000AA};

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_LOAD = 2'd1,
    PM_RUN  = 2'd2
  } pm_state_t;

endpackage

// File: rtl/program_memory_if.sv
// Load-stream and fetch bundle between a host/processor and program_memory.
// master drives loads and fetch addresses; slave is the memory.
interface program_memory_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28
);

    logic                   iProgStart;
    logic [INSTR_WIDTH-1:0] iProgData;
    logic                   iProgValid;
    logic                   iProgLast;
    logic                   oProgReady;
    logic                   oProgDone;
    logic [ADDR_WIDTH:0]    oLength;
    logic [ADDR_WIDTH-1:0]  iAddress;
    logic                   iStall;
    logic [INSTR_WIDTH-1:0] oInstruction;
    logic                   oValid;
    logic                   oParityError;

    modport master (
        output iProgStart, iProgData, iProgValid,
        output iProgLast, iAddress, iStall,
        input  oProgReady, oProgDone, oLength,
        input  oInstruction, oValid, oParityError
    );

    modport slave (
        input  iProgStart, iProgData, iProgValid,
        input  iProgLast, iAddress, iStall,
        output oProgReady, oProgDone, oLength,
        output oInstruction, oValid, oParityError
    );

endinterface

// File: rtl/program_memory_loader.sv
// Loader FSM for program_memory: write pointer, length,
// ready and the completion pulse.
module program_memory_loader
    import program_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prog_start,
    input  logic            prog_valid,
    input  logic            prog_last,
    output pm_state_t       state,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic            prog_ready,
    output logic            prog_done,
    output logic [ADDR_WIDTH:0] length
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W =
        (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_PTR =
        (ADDR_WIDTH+1)'(DEPTH - 1);

    pm_state_t           state_n;
    logic [ADDR_WIDTH:0] ptr, ptr_n, len_n;
    logic                done_n;
    logic                accept, finish;

    assign prog_ready = (state == PM_LOAD) && (ptr < DEPTH_W);
    assign accept     = prog_ready && prog_valid;
    assign finish     = accept && (prog_last || ptr == LAST_PTR);
    assign wr_en      = accept && !rst;
    assign wr_addr    = ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PM_IDLE;
            ptr       <= '0;
            length    <= '0;
            prog_done <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            length    <= len_n;
            prog_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        len_n   = length;
        done_n  = 1'b0;
        unique case (1'b1)
            (state == PM_LOAD): begin
                if (accept) begin
                    ptr_n = ptr + 1'b1;
                end
                if (finish) begin
                    state_n = PM_RUN;
                    len_n   = ptr + 1'b1;
                    done_n  = 1'b1;
                end
            end
            (state != PM_LOAD): begin
                // An illegal encoding falls back to IDLE.
                if (state != PM_RUN) begin
                    state_n = PM_IDLE;
                end
                if (prog_start) begin
                    state_n = PM_LOAD;
                    ptr_n   = '0;
                    len_n   = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/program_memory.sv
// Run-time loadable instruction memory with registered fetch.
// Optional read parity check: define PROGRAM_MEMORY_PARITY_EN.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28,
    parameter int DEPTH       = 256,
    parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR =
        INSTR_WIDTH'(PM_DEFAULT_INSTR)
) (
    input logic             Clock,
    input logic             Reset,
    program_memory_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W =
        (ADDR_WIDTH+1)'(DEPTH);
`ifdef PROGRAM_MEMORY_PARITY_EN
    localparam int MW = INSTR_WIDTH + 1;
`else
    localparam int MW = INSTR_WIDTH;
`endif

    logic [MW-1:0]          mem [DEPTH];
    logic [MW-1:0]          wr_word, rd_word;
    logic [AW-1:0]          wr_addr, rd_idx;
    logic [ADDR_WIDTH:0]    addr_x;
    logic                   wr_en, hit, fetch, load_entry;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   valid_q, perr_q;
    pm_state_t              state;

    program_memory_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_loader (
        .clk        (Clock),
        .rst        (Reset),
        .prog_start (bus.iProgStart),
        .prog_valid (bus.iProgValid),
        .prog_last  (bus.iProgLast),
        .state      (state),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .prog_ready (bus.oProgReady),
        .prog_done  (bus.oProgDone),
        .length     (bus.oLength)
    );

`ifdef PROGRAM_MEMORY_PARITY_EN
    assign wr_word = {^bus.iProgData, bus.iProgData};
`else
    assign wr_word = bus.iProgData;
`endif

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // Both bounds checked so the array is never indexed past DEPTH.
    assign addr_x     = {1'b0, bus.iAddress};
    assign hit        = (addr_x < bus.oLength) && (addr_x < DEPTH_W);
    assign rd_idx     = bus.iAddress[AW-1:0];
    assign rd_word    = mem[rd_idx];
    assign fetch      = (state == PM_RUN) && !bus.iProgStart
                        && !bus.iStall;
    assign load_entry = (state != PM_LOAD) && bus.iProgStart;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_q <= DEFAULT_INSTR;
            valid_q <= 1'b0;
        end else if (fetch) begin
            instr_q <= hit ? rd_word[INSTR_WIDTH-1:0]
                           : DEFAULT_INSTR;
            valid_q <= 1'b1;
        end else if (state != PM_RUN || bus.iProgStart) begin
            valid_q <= 1'b0;
        end
    end

`ifdef PROGRAM_MEMORY_PARITY_EN
    always_ff @(posedge Clock) begin
        if (Reset || load_entry) begin
            perr_q <= 1'b0;
        end else if (fetch && hit && (^rd_word)) begin
            perr_q <= 1'b1;
        end
    end
`else
    assign perr_q = 1'b0;
`endif

    assign bus.oInstruction = instr_q;
    assign bus.oValid       = valid_q;
    assign bus.oParityError = perr_q;

endmodule
